// File: rtl/settings_pkg.sv
// Shared settings for the traffic test sequencer: mode encodings, default widths,
// FSM state type and the LFSR step used for random addressing.
package settings_pkg;
  localparam int DEF_ADDR_W      = 28;
  localparam int DEF_AMM_BURST_W = 11;

  typedef enum logic [1:0] {
    TM_NONE         = 2'd0,
    WRITE_ONLY      = 2'd1,
    READ_ONLY       = 2'd2,
    WRITE_AND_CHECK = 2'd3
  } test_mode_type;

  typedef enum logic [2:0] {
    FIX_ADDR = 3'd0,
    INC_ADDR = 3'd1,
    RND_ADDR = 3'd2,
    RUN_1    = 3'd3,
    RUN_0    = 3'd4
  } addr_mode_type;

  typedef struct packed {
    logic                       write;
    logic [DEF_ADDR_W-1:0]      word_address;
    logic [DEF_AMM_BURST_W-1:0] burst;
  } cmd_struct_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, WR_REQ, WR_FLUSH, RD_REQ, RD_FLUSH, DONE
  } seq_state_e;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction
endpackage

// File: rtl/test_sequencer_if.sv
// Command handshake bus between the sequencer (master) and the memory-side engine.
interface test_sequencer_if #(
  parameter int ADDR_W      = settings_pkg::DEF_ADDR_W,
  parameter int AMM_BURST_W = settings_pkg::DEF_AMM_BURST_W
);
  logic                   cmd_valid_o;
  logic                   cmd_ready_i;
  logic                   cmd_write_o;
  logic [ADDR_W-1:0]      cmd_addr_o;
  logic [AMM_BURST_W-1:0] cmd_burst_o;
  logic                   trans_idle_i;

  modport master (output cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_burst_o,
                  input  cmd_ready_i, trans_idle_i);
  modport slave  (input  cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_burst_o,
                  output cmd_ready_i, trans_idle_i);
endinterface

// File: rtl/test_sequencer_addr_gen.sv
// Per-command address generator: command counter, running INC/RUN state and LFSR.
// Random addressing is built only with TEST_SEQ_RND_ADDR_EN; otherwise RND_ADDR acts as INC_ADDR.
module addr_gen
  import settings_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int AMM_BURST_W = DEF_AMM_BURST_W,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   adv_i,
  input  addr_mode_type          mode_i,
  input  logic [ADDR_W-1:0]      base_i,
  input  logic [ADDR_W-1:0]      base_ld_i,
  input  logic [AMM_BURST_W-1:0] burst_i,
  input  logic [31:0]            seed_i,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [CNT_W-1:0]       cnt_o
);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] inc_q, inc_d, run_q, run_d, rnd_addr;

  // load and adv never coincide: load happens only while no command is offered
  always_comb begin
    cnt_d = cnt_q;
    inc_d = inc_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = '0;
      inc_d = base_ld_i;
      run_d = ADDR_W'(1);
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
      inc_d = inc_q + ADDR_W'(burst_i);
      run_d = {run_q[ADDR_W-2:0], run_q[ADDR_W-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      inc_q <= '0;
      run_q <= ADDR_W'(1);
    end else begin
      cnt_q <= cnt_d;
      inc_q <= inc_d;
      run_q <= run_d;
    end

`ifdef TEST_SEQ_RND_ADDR_EN
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)     lfsr_d = seed_i;
    else if (adv_i) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 32'h1;
    else        lfsr_q <= lfsr_d;

  assign rnd_addr = lfsr_q[ADDR_W-1:0];
`else
  logic seed_unused;
  assign seed_unused = ^seed_i;
  assign rnd_addr    = inc_q;
`endif

  always_comb begin
    case (mode_i)
      INC_ADDR: addr_o = inc_q;
      RND_ADDR: addr_o = rnd_addr;
      RUN_1:    addr_o = run_q;
      RUN_0:    addr_o = ~run_q;
      default:  addr_o = base_i;
    endcase
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/test_sequencer.sv
// Memory traffic test sequencer: write and/or read phases of trans_cnt commands each.
// Optional build macro TEST_SEQ_RND_ADDR_EN enables LFSR-driven RND_ADDR.
module test_sequencer
  import settings_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int AMM_BURST_W = DEF_AMM_BURST_W,
  parameter int CNT_W       = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             test_mode_i,
  input  logic [2:0]             addr_mode_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [AMM_BURST_W-1:0] burst_cnt_i,
  input  logic [CNT_W-1:0]       trans_cnt_i,
  input  logic [31:0]            rnd_seed_i,
  test_sequencer_if.master       cmd_if,
  output logic                   busy_o,
  output logic                   done_o
);
  typedef struct packed {
    test_mode_type          tmode;
    addr_mode_type          amode;
    logic [ADDR_W-1:0]      base;
    logic [AMM_BURST_W-1:0] burst;
    logic [CNT_W-1:0]       trans;
    logic [31:0]            seed;
  } cfg_t;

  seq_state_e        state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic              abort_q, abort_d;
  logic              load, hs, last;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] gen_addr;

  assign hs   = cmd_if.cmd_valid_o && cmd_if.cmd_ready_i;
  assign last = hs && (CNT_W'(cnt + 1'b1) == cfg_q.trans);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    abort_d = abort_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        load        = 1'b1;
        cfg_d.tmode = test_mode_type'(test_mode_i);
        cfg_d.amode = addr_mode_type'(addr_mode_i);
        cfg_d.base  = base_addr_i;
        cfg_d.burst = (burst_cnt_i == '0) ? AMM_BURST_W'(1) : burst_cnt_i;
        cfg_d.trans = trans_cnt_i;
        cfg_d.seed  = (rnd_seed_i == 32'h0) ? 32'h1 : rnd_seed_i;
        if (trans_cnt_i == '0) state_d = DONE;
        else case (cfg_d.tmode)
          WRITE_ONLY, WRITE_AND_CHECK: state_d = WR_REQ;
          READ_ONLY:                   state_d = RD_REQ;
          default:                     state_d = DONE;
        endcase
      end
      // An abort still lets a same-cycle handshake count, then leaves the phase
      WR_REQ: begin
        if (last) state_d = WR_FLUSH;
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = WR_FLUSH;
        end
      end
      WR_FLUSH: begin
        if (abort_i) abort_d = 1'b1;
        if (cmd_if.trans_idle_i) begin
          if (cfg_q.tmode == WRITE_AND_CHECK && !abort_d) begin
            state_d = RD_REQ;
            load    = 1'b1;
          end else state_d = DONE;
        end
      end
      RD_REQ: begin
        if (last || abort_i) state_d = RD_FLUSH;
      end
      RD_FLUSH: if (cmd_if.trans_idle_i) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i)
    if (!rst_sys_n_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      abort_q <= abort_d;
    end

  addr_gen #(.ADDR_W(ADDR_W), .AMM_BURST_W(AMM_BURST_W), .CNT_W(CNT_W)) u_addr_gen (
    .clk       (clk_sys_i),
    .rst_n     (rst_sys_n_i),
    .load_i    (load),
    .adv_i     (hs),
    .mode_i    (cfg_q.amode),
    .base_i    (cfg_q.base),
    .base_ld_i (cfg_d.base),
    .burst_i   (cfg_q.burst),
    .seed_i    (cfg_d.seed),
    .addr_o    (gen_addr),
    .cnt_o     (cnt)
  );

  assign cmd_if.cmd_valid_o = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign cmd_if.cmd_write_o = (state_q == WR_REQ);
  assign cmd_if.cmd_addr_o  = gen_addr;
  assign cmd_if.cmd_burst_o = cfg_q.burst;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = (state_q == DONE);
endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, width of the word address issued per command.
REQ-002 SHALL have parameter AMM_BURST_W, default 11, width of burst word count.
REQ-003 SHALL have parameter CNT_W, default 16, width of the transaction count.
REQ-004 Ports SHALL be:
- clk_sys_i  in  1  system clock; single clock domain.
- rst_sys_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse; launches a test when idle.
- abort_i  in  1  stops the test after the current handshake.
- test_mode_i  in  2  test_mode_type.
- addr_mode_i  in  3  addr_mode_type.
- base_addr_i  in  ADDR_W  fixed/start address.
- burst_cnt_i  in  AMM_BURST_W  words per command, 1..2^AMM_BURST_W-1.
- trans_cnt_i  in  CNT_W  commands per phase.
- rnd_seed_i  in  32  LFSR seed.
- cmd_valid_o  out  1  command valid.
- cmd_ready_i  in  1  downstream accepts command.
- cmd_write_o  out  1  1 = write, 0 = read.
- cmd_addr_o  out  ADDR_W  command word address.
- cmd_burst_o  out  AMM_BURST_W  command burst count.
- trans_idle_i  in  1  downstream has no outstanding transfers.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at test end.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, WR_REQ, WR_FLUSH, RD_REQ, RD_FLUSH, DONE.
REQ-006 IDLE->LOAD on start_i; start_i outside IDLE SHALL be ignored.
REQ-007 LOAD (one cycle) SHALL latch all config inputs, clear the command counter, and load the LFSR with rnd_seed_i (all-zero seed replaced by 32'h1).
REQ-008 LOAD SHALL go to WR_REQ for WRITE_ONLY/WRITE_AND_CHECK, RD_REQ for READ_ONLY, DONE for mode 0 or trans_cnt 0.
REQ-009 In WR_REQ/RD_REQ cmd_valid_o SHALL be 1; addr/burst/write SHALL stay stable while cmd_valid_o=1 and cmd_ready_i=0.
REQ-010 A command SHALL count only on cycles with cmd_valid_o=1 and cmd_ready_i=1; the next command SHALL be presented the following cycle (back-to-back, one command per clock max).
REQ-011 After trans_cnt accepted commands, *_REQ SHALL go to the matching *_FLUSH and wait for trans_idle_i=1.
REQ-012 WR_FLUSH SHALL go to RD_REQ (WRITE_AND_CHECK, counter and LFSR reloaded as in LOAD) or DONE (WRITE_ONLY); RD_FLUSH SHALL go to DONE.
REQ-013 DONE SHALL assert done_o one cycle and return to IDLE; busy_o SHALL be 1 in every state but IDLE.
REQ-014 Address for command i (0-based):
- FIX_ADDR: base.
- INC_ADDR: base + i*burst, modulo 2^ADDR_W (wraps silently).
- RND_ADDR: LFSR[ADDR_W-1:0]; LFSR (x^32+x^22+x^2+x+1, Galois) advances once per accepted command.
- RUN_1: 1 << (i mod ADDR_W).
- RUN_0: bitwise inverse of RUN_1 within ADDR_W.
- Codes 5..7: treated as FIX_ADDR.
REQ-015 The read phase of WRITE_AND_CHECK SHALL reproduce the write-phase address sequence exactly.
REQ-016 abort_i in *_REQ SHALL drop cmd_valid_o the cycle after the next handshake (or at once if cmd_valid_o is 1 with no handshake pending that cycle) and go to the matching *_FLUSH, then DONE; abort_i in IDLE/DONE SHALL be ignored.
REQ-017 Simultaneous abort_i and last handshake SHALL behave as normal completion of that phase, then DONE.
REQ-018 burst_cnt_i = 0 SHALL be latched as 1.

Reset
REQ-019 Reset SHALL force IDLE; cmd_valid_o, cmd_write_o, busy_o, done_o SHALL be 0; cmd_addr_o, cmd_burst_o, counter SHALL be 0; LFSR SHALL be 32'h1.
REQ-020 Reset mid-test SHALL abandon the test without done_o.

Configuration
REQ-021 Macro TEST_SEQ_RND_ADDR_EN defined: RND_ADDR and LFSR as in REQ-014.
REQ-022 Macro undefined: no LFSR logic; RND_ADDR SHALL behave as INC_ADDR; rnd_seed_i unused.

Structure
REQ-023 test_mode_type, addr_mode_type, ADDR_W, AMM_BURST_W defaults SHALL come from settings_pkg; a new cmd_struct_t {write, word_address, burst} SHALL be added there.
REQ-024 The address generator SHALL be sub-module addr_gen (modes, counter, LFSR, reload).

Verification
REQ-025 WRITE_ONLY, INC_ADDR, base 0x100, burst 4, count 3, ready=1 -> writes at 0x100,0x104,0x108 on consecutive cycles, done_o after trans_idle_i.
REQ-026 WRITE_AND_CHECK, RND_ADDR, seed 0xACE1, count 8 -> 8 read addresses equal the 8 write addresses in order.
REQ-027 RUN_0, ADDR_W 28, count 30 -> cmd 0 = 0xFFFFFFE, cmd 27 = 0x7FFFFFF, cmd 28 = 0xFFFFFFE.
REQ-028 cmd_ready_i low 5 cycles during cmd 1 -> outputs stable, no extra count.
REQ-029 abort_i during cmd 2 of 10, WRITE_AND_CHECK -> no read phase, done_o once after trans_idle_i.
REQ-030 rst_sys_n_i low mid-WR_REQ -> all outputs 0 immediately, no done_o; next start_i runs normally.
